// File: rtl/dpram_port_sched.sv
// Read/write port scheduler and clear engine in front of one simple dual-port RAM.
// Optional macro DPRAM_SCHED_WR_BYPASS_EN: same-cycle write/read collision returns new data.
module dpram_port_sched #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 7,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
  parameter bit                    CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  init_req,
  output logic                  init_busy,
  input  logic                  a_rd_req,
  input  logic [ADDR_WIDTH-1:0] a_rd_addr,
  output logic                  a_rd_ack,
  output logic                  a_rd_valid,
  input  logic                  b_rd_req,
  input  logic [ADDR_WIDTH-1:0] b_rd_addr,
  output logic                  b_rd_ack,
  output logic                  b_rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  output logic [ADDR_WIDTH-1:0] ram_wraddress,
  output logic [DATA_WIDTH-1:0] ram_wrdata,
  output logic                  ram_wren,
  output logic [ADDR_WIDTH-1:0] ram_rdaddress,
  input  logic [DATA_WIDTH-1:0] ram_rddata
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic                  last_b;
  logic                  a_gnt;
  logic                  b_gnt;
  logic                  a_vld_q;
  logic                  b_vld_q;
  logic                  run;

  assign run       = (state == RUN) && !rst;
  assign init_busy = (state == CLEAR);

  // round-robin read grant, at most one client per cycle
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (run) begin
      unique case (1'b1)
        a_rd_req && b_rd_req: begin
          if (last_b) a_gnt = 1'b1;
          else        b_gnt = 1'b1;
        end
        a_rd_req && !b_rd_req: a_gnt = 1'b1;
        !a_rd_req && b_rd_req: b_gnt = 1'b1;
        default: ;
      endcase
    end
  end

  assign a_rd_ack      = a_gnt;
  assign b_rd_ack      = b_gnt;
  assign wr_ack        = run && wr_req;
  assign ram_rdaddress = b_gnt ? b_rd_addr : a_rd_addr;

  // write port mux: clear engine owns it in CLEAR, client otherwise
  always_comb begin
    ram_wren      = 1'b0;
    ram_wraddress = wr_addr;
    ram_wrdata    = wr_data;
    if (!rst) begin
      if (state == CLEAR) begin
        ram_wren      = 1'b1;
        ram_wraddress = ptr;
        ram_wrdata    = CLEAR_VALUE;
      end else begin
        ram_wren = wr_req;
      end
    end
  end

  // clear/run state machine with the clear address pointer
  always_ff @(posedge clock) begin
    if (rst) begin
      ptr <= '0;
      if (CLEAR_ON_RESET) state <= CLEAR;
      else                state <= RUN;
    end else begin
      case (state)
        CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == '1) state <= RUN;
        end
        default: begin
          if (init_req) begin
            state <= CLEAR;
            ptr   <= '0;
          end
        end
      endcase
    end
  end

  // fairness pointer moves only when a grant is issued
  always_ff @(posedge clock) begin
    if (rst)        last_b <= 1'b1;
    else if (a_gnt) last_b <= 1'b0;
    else if (b_gnt) last_b <= 1'b1;
  end

  // read data qualifiers follow the grant by the RAM latency
  always_ff @(posedge clock) begin
    if (rst) begin
      a_vld_q <= 1'b0;
      b_vld_q <= 1'b0;
    end else begin
      a_vld_q <= a_gnt;
      b_vld_q <= b_gnt;
    end
  end

  assign a_rd_valid = a_vld_q;
  assign b_rd_valid = b_vld_q;

`ifdef DPRAM_SCHED_WR_BYPASS_EN
  logic                  hit_q;
  logic [DATA_WIDTH-1:0] byp_q;

  // capture a colliding write so the read sees the new word
  always_ff @(posedge clock) begin
    if (rst) begin
      hit_q <= 1'b0;
      byp_q <= '0;
    end else begin
      hit_q <= ram_wren && (a_gnt || b_gnt) &&
               (ram_wraddress == ram_rdaddress);
      byp_q <= ram_wrdata;
    end
  end

  assign rd_data = hit_q ? byp_q : ram_rddata;
`else
  assign rd_data = ram_rddata;
`endif

endmodule

// File: tb/tb_dpram_port_sched.sv
// Bench for dpram_port_sched: directed clear/arbitration/collision steps
// plus a random phase, against a behavioural model of the scheduling rules.
module tb_dpram_port_sched;
  localparam int DW = 32;
  localparam int AW = 7;
  localparam int DEPTH = 1 << AW;
  localparam logic [DW-1:0] CV = '0;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst, init_req, init_busy;
  logic a_rd_req, a_rd_ack, a_rd_valid;
  logic b_rd_req, b_rd_ack, b_rd_valid;
  logic [AW-1:0] a_rd_addr, b_rd_addr, wr_addr;
  logic [AW-1:0] ram_wraddress, ram_rdaddress;
  logic [DW-1:0] rd_data, wr_data, ram_wrdata, ram_rddata;
  logic wr_req, wr_ack, ram_wren;

  dpram_port_sched #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .CLEAR_VALUE(CV), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clock(clock), .rst(rst),
    .init_req(init_req), .init_busy(init_busy),
    .a_rd_req(a_rd_req), .a_rd_addr(a_rd_addr),
    .a_rd_ack(a_rd_ack), .a_rd_valid(a_rd_valid),
    .b_rd_req(b_rd_req), .b_rd_addr(b_rd_addr),
    .b_rd_ack(b_rd_ack), .b_rd_valid(b_rd_valid),
    .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ack(wr_ack),
    .ram_wraddress(ram_wraddress), .ram_wrdata(ram_wrdata),
    .ram_wren(ram_wren), .ram_rdaddress(ram_rdaddress),
    .ram_rddata(ram_rddata)
  );

  // RAM: 1-cycle read latency, old data on collision
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clock) begin
    if (ram_wren) ram[ram_wraddress] <= ram_wrdata;
    ram_rddata <= ram[ram_rdaddress];
  end

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_mem [DEPTH];
  int clear_left;
  bit last_a;
  int busy_cnt;
  bit g_a, g_b;
  logic [DW-1:0] last_rd;

  task automatic chk(input string tag,
                     input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one clock cycle; inputs were driven at the preceding negedge
  task automatic cycle();
    bit run, ea, eb, ew;
    logic [AW-1:0] ra;
    logic [DW-1:0] ed;
    #1;
    run = !rst && (clear_left == 0);
    ea = run && a_rd_req && (!b_rd_req || !last_a);
    eb = run && b_rd_req && (!a_rd_req || last_a);
    ew = run && wr_req;
    chk("init_busy", init_busy, clear_left > 0);
    chk("a_rd_ack", a_rd_ack, ea);
    chk("b_rd_ack", b_rd_ack, eb);
    chk("wr_ack", wr_ack, ew);
    chk("ram_wren", ram_wren,
        rst ? 1'b0 : (clear_left > 0 ? 1'b1 : wr_req));
    if (!rst && clear_left > 0) begin
      chk("clr_addr", ram_wraddress, DEPTH - clear_left);
      chk("clr_data", ram_wrdata, CV);
    end
    if (init_busy) busy_cnt++;
    ra = eb ? b_rd_addr : a_rd_addr;
    ed = exp_mem[ra];
`ifdef DPRAM_SCHED_WR_BYPASS_EN
    if (ew && wr_addr == ra) ed = wr_data;
`endif
    if (ew) exp_mem[wr_addr] = wr_data;
    if (ea) last_a = 1'b1;
    else if (eb) last_a = 1'b0;
    if (rst) begin
      clear_left = DEPTH;
      last_a = 1'b0;
    end else if (clear_left > 0) begin
      clear_left--;
      if (clear_left == 0)
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = CV;
    end else if (init_req) begin
      clear_left = DEPTH;
    end
    g_a = ea;
    g_b = eb;
    @(posedge clock);
    #1;
    chk("a_rd_valid", a_rd_valid, ea);
    chk("b_rd_valid", b_rd_valid, eb);
    if (ea || eb) begin
      chk("rd_data", rd_data, ed);
      last_rd = rd_data;
    end
    @(negedge clock);
  endtask

  task automatic rd_a(input logic [AW-1:0] addr);
    a_rd_req = 1'b1;
    a_rd_addr = addr;
    cycle();
    a_rd_req = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] addr,
                    input logic [DW-1:0] data);
    wr_req = 1'b1;
    wr_addr = addr;
    wr_data = data;
    cycle();
    wr_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    init_req = 1'b0;
    a_rd_req = 1'b0; a_rd_addr = '0;
    b_rd_req = 1'b0; b_rd_addr = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    last_rd = '0;
    busy_cnt = 0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 'x;
    repeat (2) @(posedge clock);
    @(negedge clock);

    // reset state with every request raised
    a_rd_req = 1'b1; b_rd_req = 1'b1; wr_req = 1'b1;
    #1;
    chk("rst_a_ack", a_rd_ack, 1'b0);
    chk("rst_b_ack", b_rd_ack, 1'b0);
    chk("rst_wr_ack", wr_ack, 1'b0);
    chk("rst_wren", ram_wren, 1'b0);
    chk("rst_busy", init_busy, 1'b1);
    chk("rst_a_vld", a_rd_valid, 1'b0);
    clear_left = DEPTH;
    last_a = 1'b0;
    @(negedge clock);
    a_rd_req = 1'b0; b_rd_req = 1'b0; wr_req = 1'b0;
    cycle();
    rst = 1'b0;

    // clear after reset lasts exactly DEPTH cycles
    busy_cnt = 0;
    repeat (DEPTH + 2) cycle();
    chk("t1_busy_cycles", busy_cnt, DEPTH);
    rd_a(0);   chk("t1_rd0", last_rd, CV);
    rd_a(5);   chk("t1_rd5", last_rd, CV);
    rd_a(127); chk("t1_rd127", last_rd, CV);

    // both clients requesting every cycle
    wr(3, 32'h3333_3333);
    wr(9, 32'h9999_9999);
    a_rd_req = 1'b1; a_rd_addr = 3;
    b_rd_req = 1'b1; b_rd_addr = 9;
    repeat (8) cycle();
    a_rd_req = 1'b0; b_rd_req = 1'b0;

    // write then read next cycle
    wr(5, 32'hDEAD_BEEF);
    rd_a(5);
    chk("t3_raw", last_rd, 32'hDEAD_BEEF);

    // same-cycle collision
    wr(7, 32'hCAFE_F00D);
    wr_req = 1'b1; wr_addr = 7; wr_data = 32'h1234_5678;
    rd_a(7);
    wr_req = 1'b0;
`ifdef DPRAM_SCHED_WR_BYPASS_EN
    chk("t4_collide", last_rd, 32'h1234_5678);
`else
    chk("t4_collide", last_rd, 32'hCAFE_F00D);
`endif

    // random traffic
    for (int n = 0; n < 400; n++) begin
      if (!a_rd_req || g_a) begin
        a_rd_req = 1'($urandom_range(0, 1));
        a_rd_addr = AW'($urandom);
      end
      if (!b_rd_req || g_b) begin
        b_rd_req = 1'($urandom_range(0, 1));
        b_rd_addr = AW'($urandom);
      end
      wr_req = 1'($urandom_range(0, 1));
      wr_addr = AW'($urandom);
      wr_data = $urandom;
      cycle();
    end
    a_rd_req = 1'b0; b_rd_req = 1'b0; wr_req = 1'b0;
    cycle();

    // init in RUN, reset mid-clear, ignored init during clear
    wr_req = 1'b1; wr_addr = 20; wr_data = 32'h5555_AAAA;
    init_req = 1'b1;
    cycle();
    init_req = 1'b0; wr_req = 1'b0;
    a_rd_req = 1'b1; a_rd_addr = 20;
    b_rd_req = 1'b1; b_rd_addr = 3;
    for (int n = 0; n < 40; n++) begin
      init_req = (n == 10);
      cycle();
    end
    init_req = 1'b0;
    chk("t5_ptr40", ram_wraddress, 40);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    busy_cnt = 0;
    for (int n = 0; n < DEPTH + 2; n++) begin
      init_req = (n == 60);
      cycle();
    end
    init_req = 1'b0;
    chk("t5_busy_cycles", busy_cnt, DEPTH);
    a_rd_req = 1'b0; b_rd_req = 1'b0;
    cycle();
    rd_a(20); chk("t5_rd20", last_rd, CV);
    rd_a(40); chk("t5_rd40", last_rd, CV);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
